seq_restoring_divider: RTL and testbench

- Sequential radix-2 restoring unsigned divider; the inverse operation of the team's 8x8 Wallace tree multiplier.
- Takes a DIVIDEND_W-bit dividend (default 16, the multiplier's product width) and a DIVISOR_W-bit divisor (default 8).
- Returns quotient and remainder over valid/ready handshakes at both ends, producing one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 23 ++
 rtl/seq_restoring_divider.sv | 182 ++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_DIVIDEND_W = 16;
  localparam int DIV_DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Operations that finish after a single BUSY cycle instead of the full loop
  typedef enum logic [1:0] {
    SHORT_NONE  = 2'd0,
    SHORT_DBZ   = 2'd1,
    SHORT_EARLY = 2'd2
  } div_short_e;

  // Width of a counter that must hold the value dividend_w
  function automatic int div_cnt_w(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// try to subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] partial_rem,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] partial_rem_next,
  output logic                 quotient_bit
);

  logic [DIVISOR_W:0] trial;

  // Trial subtraction; the difference always fits because partial_rem < divisor
  always_comb begin
    trial            = {partial_rem, dividend_bit};
    quotient_bit     = (trial >= {1'b0, divisor});
    partial_rem_next = quotient_bit ? DIVISOR_W'(trial - {1'b0, divisor})
                                    : trial[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring unsigned divider, one quotient bit per clock.
// Optional build macro DIV_EARLY_EXIT_EN: when dividend < divisor (divisor
// non-zero) the result is produced after a single cycle instead of the full loop.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// BUSY  | iterating; counter holds remaining steps
// DONE  | out_valid high, result held until out_ready
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = div_cnt_w(DIVIDEND_W);

  div_state_e            state_q,     state_d;
  div_short_e            short_q,     short_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q,       dvd_d;
  logic [DIVISOR_W-1:0]  rem_q,       rem_d;
  logic [DIVISOR_W-1:0]  dsr_q,       dsr_d;
  logic [DIVIDEND_W-1:0] quotient_q,  quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q,       dbz_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q,  in_ready_d;

  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_qbit;

`ifdef DIV_EARLY_EXIT_EN
  logic [DIVIDEND_W-1:0] dsr_ext;
`endif

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .partial_rem     (rem_q),
    .dividend_bit    (dvd_q[DIVIDEND_W-1]),
    .divisor         (dsr_q),
    .partial_rem_next(step_rem),
    .quotient_bit    (step_qbit)
  );

  // Next-state logic for the FSM, datapath registers and registered outputs
  always_comb begin
    state_d     = state_q;
    short_d     = short_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef DIV_EARLY_EXIT_EN
    dsr_ext                  = '0;
    dsr_ext[DIVISOR_W-1:0]   = divisor;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d      = dividend;
          dsr_d      = divisor;
          rem_d      = '0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
          // Divide-by-zero (and optionally dividend < divisor) use a one-cycle
          // pass through BUSY so their latency is exactly one edge.
          if (divisor == '0) begin
            cnt_d   = CNT_W'(1);
            short_d = SHORT_DBZ;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (dividend < dsr_ext) begin
            cnt_d   = CNT_W'(1);
            short_d = SHORT_EARLY;
          end
`endif
          else begin
            cnt_d   = CNT_W'(DIVIDEND_W);
            short_d = SHORT_NONE;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        dvd_d = {dvd_q[DIVIDEND_W-2:0], step_qbit};
        rem_d = step_rem;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          case (short_q)
            SHORT_DBZ: begin
              quotient_d  = '1;
              remainder_d = dvd_q[DIVISOR_W-1:0];
              dbz_d       = 1'b1;
            end
            SHORT_EARLY: begin
              quotient_d  = '0;
              remainder_d = dvd_q[DIVISOR_W-1:0];
              dbz_d       = 1'b0;
            end
            default: begin
              quotient_d  = {dvd_q[DIVIDEND_W-2:0], step_qbit};
              remainder_d = step_rem;
              dbz_d       = 1'b0;
            end
          endcase
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      short_q     <= SHORT_NONE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      short_q     <= short_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (default 16/8 widths).
module tb_seq_restoring_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          hold;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   acc_cyc[$];

  seq_restoring_divider #(
    .DIVIDEND_W(16),
    .DIVISOR_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_latency(input logic [15:0] a, input logic [7:0] b);
    if (b == 8'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
    if (a < {8'd0, b}) return 1;
`endif
    return 16;
  endfunction

  // Issue one operation, measure latency, check result, optionally stall in DONE
  task automatic do_op(input vec_t v, output int acc);
    exp_t e;
    exp_t got;
    int   n;
    int   lat;
    e.q = v.q; e.r = v.r; e.dbz = v.dbz;
    sb_q.push_back(e);
    lat = exp_latency(v.a, v.b);

    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = v.a;
    divisor   = v.b;
    out_ready = (v.hold == 0);
    @(posedge clk);
    acc = cyc;
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);

    n = 0;
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0) chk("in_ready_low_busy", in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("in_ready_low_done", in_ready, 0);

    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      got = sb_q.pop_front();
      chk("quotient", quotient, got.q);
      chk("remainder", remainder, got.r);
      chk("div_by_zero", div_by_zero, got.dbz);
    end

    for (int k = 0; k < v.hold; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'd3;
      divisor  = 8'd1;
      chk("hold_valid", out_valid, 1);
      chk("hold_quotient", quotient, e.q);
      chk("hold_remainder", remainder, e.r);
      chk("hold_in_ready", in_ready, 0);
    end
    if (v.hold > 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    vec_t v;
    int   acc;
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs.push_back('{16'd100,   8'd7,   16'd14,    8'd2,   1'b0, 0});
    vecs.push_back('{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 0});
    vecs.push_back('{16'hFFFF,  8'hFF,  16'd257,   8'd0,   1'b0, 0});
    vecs.push_back('{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 0});
    vecs.push_back('{16'd12345, 8'd123, 16'd100,   8'd45,  1'b0, 0});
    vecs.push_back('{16'd5000,  8'd13,  16'd384,   8'd8,   1'b0, 5});
    vecs.push_back('{16'd5,     8'd9,   16'd0,     8'd5,   1'b0, 0});
    vecs.push_back('{16'd40000, 8'd254, 16'd157,   8'd122, 1'b0, 0});
    vecs.push_back('{16'd256,   8'd255, 16'd1,     8'd1,   1'b0, 0});
    vecs.push_back('{16'd254,   8'd255, 16'd0,     8'd254, 1'b0, 0});
    vecs.push_back('{16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 0});
    vecs.push_back('{16'd65535, 8'd0,   16'hFFFF,  8'hFF,  1'b1, 0});

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_op(v, acc);
      acc_cyc.push_back(acc);
    end
    chk("issue_interval_ge18", (acc_cyc[2] - acc_cyc[1]) >= 18, 1);

    // Reset mid-operation: accept 40000/200, assert rst_n during BUSY cycle 7
    @(negedge clk);
    in_valid  = 1'b1;
    dividend  = 16'd40000;
    divisor   = 8'd200;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("pre_reset_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) chk("aborted_never_presented", out_valid, 0);
    end
    v = '{16'd40000, 8'd200, 16'd200, 8'd0, 1'b0, 0};
    do_op(v, acc);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
